// File: rtl/cpu_init_loader.sv
`timescale 1ns/1ps
// Boot-time initialiser for the CPU: clears the BTB, BHT and register file,
// then streams host records into them before releasing the CPU to run.
module cpu_init_loader #(
   parameter int          HOLD         = 2,
   parameter logic [1:0]  BHT_INIT_VAL = 2'b01
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        go,
   input  logic        load_valid,
   output logic        load_ready,
   input  logic [1:0]  load_target,
   input  logic [7:0]  load_addr,
   input  logic [39:0] load_data,
   input  logic        load_last,
   input  logic        toss_npu,
   output logic [7:0]  btb_addr,
   output logic [39:0] btb_init,
   output logic        btb_we,
   output logic [7:0]  bht_addr,
   output logic [1:0]  bht_init,
   output logic        bht_we,
   output logic [4:0]  reg_addr,
   output logic [31:0] reg_init,
   output logic        reg_we,
   output logic        start_switch,
   output logic        busy,
   output logic        done,
   output logic        err
);

   typedef enum logic [2:0] {IDLE, CLR_BTB, CLR_BHT, CLR_REG, LOAD, RUN} state_t;

   localparam int HW = (HOLD > 1) ? $clog2(HOLD) : 1;

   state_t        state, next_state;
   logic [HW-1:0] hold;
   logic [7:0]    idx;
   logic          wr_active, wr_last;
   logic [1:0]    wr_target;
   logic [7:0]    wr_addr;
   logic [39:0]   wr_data;
   logic          done_q, err_q;
   logic          hold_last, clr_last, accept, wr_end;

   assign hold_last = (hold == HW'(HOLD - 1));
   assign clr_last  = hold_last && (idx == ((state == CLR_REG) ? 8'd31 : 8'd255));
   assign accept    = (state == LOAD) && !wr_active && load_valid;
   // An invalid record occupies a single idle cycle so load_ready still drops
   assign wr_end    = hold_last || (wr_target == 2'b11);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= IDLE;
      else      state <= next_state;
   end

   always_comb begin
      next_state = state;
      case (state)
         IDLE:    if (go) next_state = CLR_BTB;
         CLR_BTB: if (clr_last) next_state = CLR_BHT;
         CLR_BHT: if (clr_last) next_state = CLR_REG;
         CLR_REG: if (clr_last) next_state = LOAD;
         LOAD: begin
            if (accept && load_target == 2'b11 && load_last)
               next_state = RUN;
            else if (wr_active && wr_end && wr_last)
               next_state = RUN;
         end
         RUN:     if (toss_npu) next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         hold      <= '0;
         idx       <= '0;
         wr_active <= 1'b0;
         wr_last   <= 1'b0;
         wr_target <= '0;
         wr_addr   <= '0;
         wr_data   <= '0;
         done_q    <= 1'b0;
         err_q     <= 1'b0;
      end else begin
         done_q <= (state == RUN) && toss_npu;
         case (state)
            IDLE: begin
               if (go) begin
                  hold  <= '0;
                  idx   <= '0;
                  err_q <= 1'b0;
               end
            end
            CLR_BTB, CLR_BHT, CLR_REG: begin
               if (hold_last) begin
                  hold <= '0;
                  idx  <= clr_last ? 8'd0 : idx + 8'd1;
               end else begin
                  hold <= hold + HW'(1);
               end
            end
            LOAD: begin
               if (accept) begin
                  wr_target <= load_target;
                  wr_addr   <= load_addr;
                  wr_data   <= load_data;
                  wr_last   <= load_last;
                  hold      <= '0;
                  wr_active <= !(load_target == 2'b11 && load_last);
                  if (load_target == 2'b11) err_q <= 1'b1;
               end else if (wr_active) begin
                  if (wr_end) begin
                     wr_active <= 1'b0;
                     hold      <= '0;
                  end else begin
                     hold <= hold + HW'(1);
                  end
               end
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      btb_we       = 1'b0;
      btb_addr     = '0;
      btb_init     = '0;
      bht_we       = 1'b0;
      bht_addr     = '0;
      bht_init     = '0;
      reg_we       = 1'b0;
      reg_addr     = '0;
      reg_init     = '0;
      load_ready   = 1'b0;
      start_switch = 1'b0;
      case (state)
         CLR_BTB: begin
            btb_we   = 1'b1;
            btb_addr = idx;
         end
         CLR_BHT: begin
            bht_we   = 1'b1;
            bht_addr = idx;
            bht_init = BHT_INIT_VAL;
         end
         CLR_REG: begin
            reg_we   = 1'b1;
            reg_addr = idx[4:0];
         end
         LOAD: begin
            load_ready = !wr_active;
            if (wr_active) begin
               case (wr_target)
                  2'b00: begin
                     btb_we   = 1'b1;
                     btb_addr = wr_addr;
                     btb_init = wr_data;
                  end
                  2'b01: begin
                     bht_we   = 1'b1;
                     bht_addr = wr_addr;
                     bht_init = wr_data[1:0];
                  end
                  2'b10: begin
                     reg_we   = 1'b1;
                     reg_addr = wr_addr[4:0];
                     reg_init = wr_data[31:0];
                  end
                  default: ;
               endcase
            end
         end
         RUN:     start_switch = 1'b1;
         default: ;
      endcase
   end

   assign busy = (state != IDLE);
   assign done = done_q;
   assign err  = err_q;

endmodule

// File: tb/tb_cpu_init_loader.sv
`timescale 1ns/1ps
// Directed bench for cpu_init_loader with HOLD=2: clear timing, record loading,
// backpressure, invalid target, handoff and mid-sequence reset.
module tb_cpu_init_loader;

   logic        clk = 1'b0;
   logic        rst;
   logic        go, load_valid, load_last, toss_npu;
   logic [1:0]  load_target;
   logic [7:0]  load_addr;
   logic [39:0] load_data;
   logic        load_ready;
   logic [7:0]  btb_addr, bht_addr;
   logic [39:0] btb_init;
   logic [1:0]  bht_init;
   logic [4:0]  reg_addr;
   logic [31:0] reg_init;
   logic        btb_we, bht_we, reg_we;
   logic        start_switch, busy, done, err;

   int vectors = 0;
   int miscompares = 0;

   cpu_init_loader #(.HOLD(2), .BHT_INIT_VAL(2'b01)) dut (
      .clk(clk), .rst(rst), .go(go),
      .load_valid(load_valid), .load_ready(load_ready),
      .load_target(load_target), .load_addr(load_addr),
      .load_data(load_data), .load_last(load_last), .toss_npu(toss_npu),
      .btb_addr(btb_addr), .btb_init(btb_init), .btb_we(btb_we),
      .bht_addr(bht_addr), .bht_init(bht_init), .bht_we(bht_we),
      .reg_addr(reg_addr), .reg_init(reg_init), .reg_we(reg_we),
      .start_switch(start_switch), .busy(busy), .done(done), .err(err)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   initial begin
      logic [7:0]  a, exp_a;
      logic [1:0]  d, exp_d;
      logic        nz;
      logic [2:0]  exp_we;
      rst = 1'b0; go = 1'b0; load_valid = 1'b0; load_last = 1'b0; toss_npu = 1'b0;
      load_target = '0; load_addr = '0; load_data = '0;

      #12;
      check("reset_outputs", {busy, btb_we, bht_we, reg_we, start_switch, done, err, load_ready}, 64'd0);
      rst = 1'b1;
      tick(); tick();
      check("idle_wait", {busy, btb_we, load_ready, start_switch}, 64'd0);

      // Clear sequence, observed every cycle after the go sample
      go = 1'b1; tick(); go = 1'b0;
      for (int c = 0; c < 1088; c++) begin
         if (c < 512) begin
            a = btb_addr; d = 2'b00; nz = |btb_init;
            exp_we = 3'b100; exp_a = 8'(c / 2); exp_d = 2'b00;
         end else if (c < 1024) begin
            a = bht_addr; d = bht_init; nz = 1'b0;
            exp_we = 3'b010; exp_a = 8'((c - 512) / 2); exp_d = 2'b01;
         end else begin
            a = {3'b000, reg_addr}; d = 2'b00; nz = |reg_init;
            exp_we = 3'b001; exp_a = 8'((c - 1024) / 2); exp_d = 2'b00;
         end
         check($sformatf("clear_c%0d", c), {btb_we, bht_we, reg_we, load_ready, a, d, nz},
               {exp_we, 1'b0, exp_a, exp_d, 1'b0});
         tick();
      end
      check("load_ready_1088", {busy, load_ready, btb_we, bht_we, reg_we}, 64'b11000);

      // BTB record, then a REG record presented during its hold
      load_valid = 1'b1; load_target = 2'b00; load_addr = 8'h10;
      load_data = 40'h12_3456_789A; load_last = 1'b0;
      tick();
      check("btb_rec_h1", {btb_we, bht_we, reg_we, load_ready, btb_addr, btb_init},
            {4'b1000, 8'h10, 40'h12_3456_789A});
      load_target = 2'b10; load_addr = 8'h05; load_data = 40'hAB_DEAD_BEEF; load_last = 1'b1;
      tick();
      check("btb_rec_h2", {btb_we, bht_we, reg_we, load_ready, btb_addr, btb_init},
            {4'b1000, 8'h10, 40'h12_3456_789A});
      tick();
      check("ready_gap", {btb_we, bht_we, reg_we, load_ready, start_switch}, 64'b00010);
      tick();
      check("reg_rec_h1", {btb_we, bht_we, reg_we, load_ready, reg_addr, reg_init},
            {4'b0010, 5'h05, 32'hDEAD_BEEF});
      load_valid = 1'b0; load_last = 1'b0;
      tick();
      check("reg_rec_h2", {btb_we, bht_we, reg_we, load_ready, reg_addr, reg_init},
            {4'b0010, 5'h05, 32'hDEAD_BEEF});
      tick();
      check("run_entry", {start_switch, busy, btb_we, bht_we, reg_we, load_ready, done, err},
            64'b11000000);
      go = 1'b1; tick(); go = 1'b0;
      check("run_ignores_go", {start_switch, busy, btb_we}, 64'b110);

      // Handoff
      toss_npu = 1'b1; tick(); toss_npu = 1'b0;
      check("handoff", {done, start_switch, busy}, 64'b100);
      tick();
      check("done_one_cycle", {done, start_switch, busy}, 64'b000);
      go = 1'b1; tick(); go = 1'b0;
      check("restart_idx0", {busy, btb_we, btb_addr}, {2'b11, 8'h00});

      // Invalid target with last
      repeat (1088) tick();
      check("load_ready_again", {busy, load_ready}, 64'b11);
      load_valid = 1'b1; load_target = 2'b11; load_addr = 8'h33;
      load_data = 40'h1; load_last = 1'b1;
      tick();
      load_valid = 1'b0; load_last = 1'b0;
      check("invalid_target", {start_switch, err, btb_we, bht_we, reg_we, load_ready}, 64'b110000);
      toss_npu = 1'b1; tick(); toss_npu = 1'b0;
      check("invalid_handoff", {done, err, start_switch}, 64'b110);
      go = 1'b1; tick(); go = 1'b0;
      check("err_cleared", {err, btb_we, btb_addr}, {2'b01, 8'h00});

      // Reset in the middle of the BHT clear
      repeat (712) tick();
      check("bht_idx100", {bht_we, bht_addr, bht_init}, {1'b1, 8'd100, 2'b01});
      #3 rst = 1'b0;
      #1;
      check("async_abort", {busy, btb_we, bht_we, reg_we, start_switch, done, err, load_ready, bht_addr},
            64'd0);
      tick(); tick();
      check("reset_hold", {busy, done, bht_we}, 64'd0);
      rst = 1'b1;
      tick();
      check("post_reset_idle", {busy, btb_we, done}, 64'd0);
      go = 1'b1; tick(); go = 1'b0;
      check("post_reset_restart", {busy, btb_we, bht_we, btb_addr}, {3'b110, 8'h00});
      tick(); tick();
      check("post_reset_idx1", {btb_we, btb_addr}, {1'b1, 8'h01});

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
